mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Data-side responder for the pipeline core's memory port (mem_ren/mem_wen/mem_addr/mem_dout/mem_din).
- Serves word accesses from an on-chip data RAM and a memory-mapped countdown timer.
- The timer drives the core's interrupter input.
- Zero-wait-state: read data is valid in the same cycle as the request; writes commit on the clock edge.

Parameters:
- ADDR_W, 10, RAM word-address width (depth = 2^ADDR_W words).
- PRESCALE, 1, clocks per timer tick (>=1).
- INIT_FILE, "", optional $readmemh image for RAM (empty = no init).

Ports:
- clk  in  1  main clock
- rst_n  in  1  synchronous reset, active-low
- mem_ren  in  1  read request from core
- mem_wen  in  1  write request from core
- mem_addr  in  32  byte address, word-aligned
- mem_dout  in  32  write data from core
- mem_din  out  32  read data to core
- irq  out  1  timer interrupt, level, to core interrupter
- bus_err  out  1  sticky access-error flag (see Optional Feature)

Behaviour:
- Reset is synchronous and active-low: when rst_n is low at the clk edge, state is reset.
- Reset values:
  - timer CTRL=0, LOAD=0, COUNT=0, PEND=0, prescaler=0, bus_err=0, irq=0.
  - mem_din=0 while rst_n low.
  - RAM contents not reset.
- Address decode (mem_addr[1:0] ignored unless the optional feature is on):
  - RAM: mem_addr[31:16]==16'h0000; word index mem_addr[ADDR_W+1:2]; upper bits inside the region alias.
  - TIMER: mem_addr[31:4]==28'hFFFF000. Offset 0x0 CTRL, 0x4 LOAD, 0x8 COUNT, 0xC STATUS.
  - Anything else is unmapped.
- Reads:
  - Combinational: mem_din = selected data when mem_ren=1, else 0.
  - Unmapped reads return 0.
  - CTRL: bit0 EN, bit1 AUTO, bit2 IE; other bits read 0.
  - STATUS: bit0 PEND.
- Writes:
  - Committed at the clk edge when mem_wen=1.
  - If mem_ren and mem_wen are both set, the write occurs and mem_din shows the old value (read-before-write).
  - Writing CTRL with EN 0->1 clears the prescaler.
  - Writing COUNT loads the counter.
  - Writing STATUS with bit0=1 clears PEND; writing 0 has no effect.
  - Unmapped writes are dropped.
- Timer:
  - Prescaler counts 0..PRESCALE-1 while EN=1; tick occurs when the prescaler wraps.
  - On a tick with COUNT!=0: COUNT decrements by 1.
  - On a tick with COUNT==0:
    - PEND is set.
    - If AUTO=1, COUNT is reloaded with LOAD.
    - If AUTO=0, EN clears and COUNT stays 0.
  - EN=0 freezes COUNT and the prescaler.
  - irq = PEND & IE, registered.
  - Period with AUTO=1 is (LOAD+1)*PRESCALE cycles.
- Simultaneous events:
  - Software COUNT write and tick in the same cycle: the write wins.
  - STATUS clear and expiry in the same cycle: set wins (PEND stays 1).
  - CTRL write clearing EN in the same cycle as an expiry tick: the tick is discarded and PEND is unchanged.
- Reset mid-operation: a pending write is dropped and all timer state returns to reset values the next cycle.

Optional Feature:
- Macro: MEM_RESP_BUS_ERR_EN.
- Defined:
  - Unmapped access, or an access with mem_addr[1:0]!=0, sets bus_err on the next edge.
  - bus_err stays set until a write of 1 to STATUS bit1.
  - STATUS bit1 reads bus_err.
  - Misaligned writes are dropped; misaligned reads return 0.
- Not defined:
  - bus_err is tied 0 and STATUS bit1 reads 0.
  - mem_addr[1:0] is ignored and misaligned accesses act on the containing word.

Test Plan:
- RAM: write 0x12345678 to 0x00000040, then read 0x00000040 -> mem_din=0x12345678 in the same cycle. Read 0x00000044 (unwritten, INIT_FILE empty) -> X-free after any write; check aliasing: 0x00001040 with ADDR_W=10 returns 0x12345678.
- Timer, PRESCALE=1: write LOAD=3, COUNT=3, CTRL=0x7 -> PEND and irq rise 4 cycles after the CTRL write, then COUNT reloads 3. Period is 4 cycles thereafter. Write STATUS=1 -> irq drops the next cycle.
- One-shot: CTRL=0x5, COUNT=2 -> PEND after 3 ticks, CTRL reads 0x4, COUNT holds 0, no further PEND after a clear.
- Collision: STATUS clear in the same cycle as expiry -> PEND remains 1. COUNT write of 9 in the same cycle as a tick -> COUNT reads 9 next cycle.
- Reset: assert rst_n=0 for 1 cycle while the timer is running with PEND=1 -> irq=0, CTRL=0, COUNT=0 the next cycle. RAM data written before reset is still readable.
- With MEM_RESP_BUS_ERR_EN: read 0x80000000 -> mem_din=0, bus_err=1 the next cycle. Write 0x00000042 -> RAM unchanged, bus_err=1. Write STATUS=2 -> bus_err=0. Without the macro, the same stimulus leaves bus_err=0 and the write lands in word 0x40.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: data-side responder for the pipeline core's memory port.
// Zero-wait-state word accesses to an on-chip RAM and a memory-mapped
// countdown timer whose level interrupt feeds the core's interrupter.
//
// Optional feature macro: MEM_RESP_BUS_ERR_EN
//   defined   -> unmapped or misaligned accesses raise a sticky bus_err,
//                misaligned reads return 0 and misaligned writes are dropped,
//                STATUS bit1 reads bus_err and a write of 1 there clears it.
//   undefined -> bus_err is tied 0 and mem_addr[1:0] is ignored.
//
// Request protocol: mem_ren/mem_wen are single-cycle qualifiers with no
// back-pressure. A read returns data combinationally in the same cycle;
// a write commits on the rising clk edge. With both set, mem_din shows the
// value from before the write.
//
// Timer map (base 0xFFFF_0000): 0x0 CTRL {IE,AUTO,EN}, 0x4 LOAD, 0x8 COUNT,
// 0xC STATUS {bus_err,PEND}.
//
// INIT_FILE is accepted so that image-preloading flows can pass the same
// parameter set; this RTL leaves the RAM contents uninitialised.
module mem_responder #(
  parameter int ADDR_W   = 10,
  parameter int PRESCALE = 1,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        irq,
  output logic        bus_err
);

  localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [31:0] ram [0:(1<<ADDR_W)-1];

  logic             en_q, auto_q, ie_q, pend_q, irq_q;
  logic [31:0]      load_q, count_q;
  logic [PSC_W-1:0] psc_q;

  logic             en_d, auto_d, ie_d, pend_d;
  logic [31:0]      load_d, count_d;
  logic [PSC_W-1:0] psc_d;

  logic              ram_sel, tmr_sel, acc_ok;
  logic [1:0]        reg_off;
  logic [ADDR_W-1:0] word_idx;
  logic              tmr_wr, ctrl_wr, load_wr, count_wr, status_wr;
  logic              tick, tick_kill;
  logic [31:0]       rd_data;
  logic              berr_flag;
  logic              unused_addr;

  // Region decode; upper bits inside the RAM region alias onto the array.
  assign ram_sel  = (mem_addr[31:16] == 16'h0000);
  assign tmr_sel  = (mem_addr[31:4] == 28'hFFFF000);
  assign reg_off  = mem_addr[3:2];
  assign word_idx = mem_addr[ADDR_W+1:2];

`ifdef MEM_RESP_BUS_ERR_EN
  assign acc_ok = (mem_addr[1:0] == 2'b00);
`else
  assign acc_ok = 1'b1;
`endif

  assign unused_addr = ^{mem_addr[15:ADDR_W+2], mem_addr[1:0]};

  assign tmr_wr    = mem_wen && tmr_sel && acc_ok;
  assign ctrl_wr   = tmr_wr && (reg_off == 2'd0);
  assign load_wr   = tmr_wr && (reg_off == 2'd1);
  assign count_wr  = tmr_wr && (reg_off == 2'd2);
  assign status_wr = tmr_wr && (reg_off == 2'd3);

  // A tick is the prescaler wrapping while the timer runs. Software stopping
  // the timer on the same edge throws the tick away entirely.
  assign tick      = en_q && (psc_q == PSC_LAST);
  assign tick_kill = ctrl_wr && !mem_dout[0];

  // RAM write port; writes during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst_n && mem_wen && ram_sel && acc_ok) begin
      ram[word_idx] <= mem_dout;
    end
  end

  // Timer next state: STATUS clear, then tick effects, then software writes,
  // so an expiry re-asserts PEND and a COUNT write overrides the tick.
  always_comb begin
    en_d    = en_q;
    auto_d  = auto_q;
    ie_d    = ie_q;
    pend_d  = pend_q;
    load_d  = load_q;
    count_d = count_q;
    psc_d   = psc_q;
    if (ctrl_wr && mem_dout[0] && !en_q) begin
      psc_d = '0;
    end else if (en_q) begin
      psc_d = tick ? '0 : psc_q + PSC_W'(1);
    end
    if (status_wr && mem_dout[0]) begin
      pend_d = 1'b0;
    end
    if (tick && !tick_kill) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        pend_d = 1'b1;
        if (auto_q) begin
          count_d = load_q;
        end else begin
          en_d = 1'b0;
        end
      end
    end
    if (ctrl_wr) begin
      en_d   = mem_dout[0];
      auto_d = mem_dout[1];
      ie_d   = mem_dout[2];
    end
    if (load_wr) begin
      load_d = mem_dout;
    end
    if (count_wr) begin
      count_d = mem_dout;
    end
  end

  // Timer registers; irq is registered from the post-edge PEND and IE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      pend_q  <= 1'b0;
      load_q  <= 32'd0;
      count_q <= 32'd0;
      psc_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      en_q    <= en_d;
      auto_q  <= auto_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
      load_q  <= load_d;
      count_q <= count_d;
      psc_q   <= psc_d;
      irq_q   <= pend_d & ie_d;
    end
  end

  assign irq = irq_q;

`ifdef MEM_RESP_BUS_ERR_EN
  logic berr_q, berr_d;

  // Sticky error: any request outside the map or off word alignment sets it.
  always_comb begin
    berr_d = berr_q;
    if (status_wr && mem_dout[1]) begin
      berr_d = 1'b0;
    end
    if ((mem_ren || mem_wen) && !((ram_sel || tmr_sel) && acc_ok)) begin
      berr_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      berr_q <= 1'b0;
    end else begin
      berr_q <= berr_d;
    end
  end

  assign berr_flag = berr_q;
`else
  assign berr_flag = 1'b0;
`endif

  assign bus_err = berr_flag;

  // Combinational read mux; idle, reset and rejected reads return 0.
  always_comb begin
    rd_data = 32'h0;
    if (ram_sel) begin
      rd_data = ram[word_idx];
    end else if (tmr_sel) begin
      case (reg_off)
        2'd0:    rd_data = {29'h0, ie_q, auto_q, en_q};
        2'd1:    rd_data = load_q;
        2'd2:    rd_data = count_q;
        default: rd_data = {30'h0, berr_flag, pend_q};
      endcase
    end
    mem_din = (rst_n && mem_ren && acc_ok) ? rd_data : 32'h0;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed literal checks followed by randomized traffic,
// all compared against a behavioural model of the responder kept in the bench.
module tb_mem_responder;

  localparam int ADDR_W   = 10;
  localparam int PRESCALE = 1;
`ifdef MEM_RESP_BUS_ERR_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif
  localparam logic [31:0] A_CTRL   = 32'hFFFF_0000;
  localparam logic [31:0] A_LOAD   = 32'hFFFF_0004;
  localparam logic [31:0] A_COUNT  = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_dout = 32'h0;
  wire  [31:0] mem_din;
  wire         irq;
  wire         bus_err;

  mem_responder #(
    .ADDR_W   (ADDR_W),
    .PRESCALE (PRESCALE),
    .INIT_FILE("")
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .irq      (irq),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_on   = 1'b0;
  logic [31:0] exp_q[$];

  // ---------------- behavioural model ----------------
  logic [31:0] mram [int];
  bit          m_en, m_auto, m_ie, m_pend, m_irq, m_berr;
  logic [31:0] m_load, m_count;
  int          m_psc;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // What the core should see on mem_din this cycle given the model state.
  function automatic void exp_read(input bit rn, input bit r, input logic [31:0] a,
                                   output logic [31:0] e, output bit known);
    int idx;
    known = 1'b1;
    e = 32'h0;
    if (!rn || !r) return;
    if (FEAT && (a[1:0] != 2'b00)) return;
    if (a[31:16] == 16'h0000) begin
      idx = int'(a[ADDR_W+1:2]);
      if (mram.exists(idx)) e = mram[idx];
      else known = 1'b0;
    end else if (a[31:4] == 28'hFFFF000) begin
      case (a[3:2])
        2'd0:    e = {29'h0, m_ie, m_auto, m_en};
        2'd1:    e = m_load;
        2'd2:    e = m_count;
        default: e = {30'h0, m_berr, m_pend};
      endcase
    end
  endfunction

  // Apply one clock edge worth of behaviour to the model.
  task automatic model_edge(input bit rn, input bit r, input bit w,
                            input logic [31:0] a, input logic [31:0] d);
    bit is_ram, is_tmr, aligned, tw, ticks, stopped_by_sw;
    logic [1:0] off;
    if (!rn) begin
      m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0; m_irq = 0; m_berr = 0;
      m_load = 0; m_count = 0; m_psc = 0;
      return;
    end
    is_ram  = (a[31:16] == 16'h0000);
    is_tmr  = (a[31:4] == 28'hFFFF000);
    aligned = FEAT ? (a[1:0] == 2'b00) : 1'b1;
    off     = a[3:2];
    if (w && aligned && is_ram) mram[int'(a[ADDR_W+1:2])] = d;
    tw            = w && aligned && is_tmr;
    ticks         = m_en && (m_psc == PRESCALE - 1);
    stopped_by_sw = tw && (off == 2'd0) && !d[0];
    if (tw && (off == 2'd0) && d[0] && !m_en) m_psc = 0;
    else if (m_en) m_psc = ticks ? 0 : m_psc + 1;
    // a clear on the expiry edge loses to the expiry
    if (tw && (off == 2'd3) && d[0]) m_pend = 0;
    if (ticks && !stopped_by_sw) begin
      if (m_count != 0) m_count = m_count - 1;
      else begin
        m_pend = 1;
        if (m_auto) m_count = m_load;
        else m_en = 0;
      end
    end
    if (tw && (off == 2'd0)) begin
      m_en = d[0]; m_auto = d[1]; m_ie = d[2];
    end
    if (tw && (off == 2'd1)) m_load = d;
    if (tw && (off == 2'd2)) m_count = d;
    m_irq = m_pend & m_ie;
    if (FEAT) begin
      if (tw && (off == 2'd3) && d[1]) m_berr = 0;
      if ((r || w) && !((is_ram || is_tmr) && aligned)) m_berr = 1;
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  logic [31:0] cp_e;
  bit          cp_known;
  always @(negedge clk) begin
    if (chk_on) begin
      exp_read(rst_n, mem_ren, mem_addr, cp_e, cp_known);
      if (cp_known) cmp("model_mem_din", mem_din, cp_e);
      cmp("model_irq", {31'h0, irq}, {31'h0, m_irq});
      cmp("model_bus_err", {31'h0, bus_err}, {31'h0, m_berr});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit rn, input bit r, input bit w,
                     input logic [31:0] a, input logic [31:0] d);
    rst_n = rn; mem_ren = r; mem_wen = w; mem_addr = a; mem_dout = d;
    @(posedge clk);
    model_edge(rn, r, w, a, d);
    chk_on = 1'b1;
    #1;
  endtask

  task automatic cyc_chk(input bit rn, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d,
                         input string nm, input logic [31:0] e, input int e_irq);
    rst_n = rn; mem_ren = r; mem_wen = w; mem_addr = a; mem_dout = d;
    exp_q.push_back(e);
    @(negedge clk);
    cmp(nm, mem_din, exp_q.pop_front());
    if (e_irq >= 0) cmp({nm, "_irq"}, {31'h0, irq}, e_irq[31:0]);
    @(posedge clk);
    model_edge(rn, r, w, a, d);
    chk_on = 1'b1;
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm, input int e_irq);
    cyc_chk(1'b1, 1'b1, 1'b0, a, 32'h0, nm, e, e_irq);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  int          kind;
  logic [1:0]  lo, off;
  logic [31:0] ra, rdat;
  bit          rr, rw, rrn;

  initial begin
    // reset and RAM basics
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc_chk(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, "reset_din", 32'h0, 0);
    wr(32'h40, 32'h1234_5678);
    rd(32'h40, 32'h1234_5678, "ram_rd", -1);
    rd(32'h1040, 32'h1234_5678, "ram_alias", -1);
    wr(32'h44, 32'hA5A5_A5A5);
    rd(32'h44, 32'hA5A5_A5A5, "ram_rd2", -1);
    cyc_chk(1'b1, 1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, "rbw_old", 32'h1234_5678, -1);
    rd(32'h40, 32'hCAFE_F00D, "rbw_new", -1);

    // auto-reload timer, period 4
    wr(A_LOAD, 32'd3);
    wr(A_COUNT, 32'd3);
    wr(A_CTRL, 32'h7);
    rd(A_COUNT, 32'd3, "cnt_a3", 0);
    rd(A_COUNT, 32'd2, "cnt_a2", 0);
    rd(A_COUNT, 32'd1, "cnt_a1", 0);
    rd(A_COUNT, 32'd0, "cnt_a0", 0);
    rd(A_COUNT, 32'd3, "cnt_reload", 1);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'h0, "status_clr", 0);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'h1, "set_wins", 1);
    wr(A_COUNT, 32'd9);
    rd(A_COUNT, 32'd9, "count_wr_wins", 1);

    // one-shot
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
    wr(A_COUNT, 32'd2);
    wr(A_CTRL, 32'h5);
    rd(A_CTRL, 32'h5, "os_ctrl2", 0);
    rd(A_CTRL, 32'h5, "os_ctrl1", 0);
    rd(A_CTRL, 32'h5, "os_ctrl0", 0);
    rd(A_CTRL, 32'h4, "os_ctrl_done", 1);
    rd(A_COUNT, 32'd0, "os_count", 1);
    rd(A_STATUS, 32'h1, "os_pend", 1);
    wr(A_STATUS, 32'h1);
    idle(4);
    rd(A_STATUS, 32'h0, "os_no_repend", 0);

    // reset while running with PEND set; the write alongside it is dropped
    wr(A_LOAD, 32'd1);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h7);
    idle(1);
    rd(A_STATUS, 32'h1, "pre_rst_pend", 1);
    cyc(1'b0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    rd(A_CTRL, 32'h0, "rst_ctrl", 0);
    rd(A_COUNT, 32'h0, "rst_count", 0);
    rd(32'h40, 32'hCAFE_F00D, "rst_ram", -1);

    // error flag behaviour (present only with the feature built in)
    rd(32'h8000_0000, 32'h0, "unmapped_rd", -1);
    cmp("bus_err_set", {31'h0, bus_err}, {31'h0, FEAT});
    wr(32'h42, 32'h1111_1111);
    cmp("bus_err_mis", {31'h0, bus_err}, {31'h0, FEAT});
    rd(32'h40, FEAT ? 32'hCAFE_F00D : 32'h1111_1111, "misaligned_wr", -1);
    wr(A_STATUS, 32'h2);
    cmp("bus_err_clr", {31'h0, bus_err}, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      kind = $urandom_range(0, 9);
      lo   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      off  = 2'($urandom_range(0, 3));
      rdat = $urandom;
      if (kind <= 3) begin
        ra = {16'h0, 4'($urandom_range(0, 15)), 6'h0, 4'($urandom_range(0, 15)), lo};
      end else if (kind <= 7) begin
        ra = {28'hFFFF000, off, lo};
        if (off == 2'd1 || off == 2'd2) rdat = $urandom_range(0, 6);
        else if (off == 2'd3) rdat = $urandom_range(0, 3);
      end else if (kind == 8) begin
        ra = {16'h0001 + 16'($urandom_range(0, 100)), 16'($urandom)};
      end else begin
        ra = {28'hFFFF001, 4'($urandom_range(0, 15))};
      end
      rr  = ($urandom_range(0, 1) == 1);
      rw  = ($urandom_range(0, 2) == 0);
      rrn = ($urandom_range(0, 299) != 0);
      cyc(rrn, rr, rw, ra, rdat);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
